// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC sample packetizer.
// Packet layout: 4-byte big-endian sequence header, then I/Q pairs.
package adc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        SAMP   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam int HDR_BYTES     = 4;
    localparam int BYTES_PER_SMP = 4;
    localparam int VLD_BIT       = 33;
    localparam int PAR_BIT       = 32;

    function automatic int pkt_bytes(input int samples);
        return HDR_BYTES + BYTES_PER_SMP * samples;
    endfunction

    // Byte idx of a 32-bit word, most significant byte first.
    function automatic logic [7:0] be_byte(input logic [31:0] w,
                                           input logic [1:0]  idx);
        logic [7:0] b;
        unique case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_pkt_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Only the read register is reset so the array still maps to block RAM.
module adc_pkt_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_udp_packetizer.sv
// Frames parity-checked ADC I/Q samples into sequence-numbered packets
// and exposes only fully committed packets on a SOP/EOP byte port.
module adc_udp_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int SAMPLES_PER_PKT = 256,
    parameter int ADDR_W          = 12,
    parameter int CNT_W           = 16
) (
    input  logic             clk125,
    input  logic             clk125_rst_n,
    input  logic [33:0]      adc_ddr_in,
    input  logic             pkt_rd,
    output logic [7:0]       pkt_byte,
    output logic             pkt_sop,
    output logic             pkt_eop,
    output logic             pkt_avail,
    output logic [CNT_W-1:0] parity_err_cnt,
    output logic [CNT_W-1:0] drop_pkt_cnt,
    output logic [CNT_W-1:0] drop_smp_cnt
);

    localparam int PKT_BYTES = pkt_bytes(SAMPLES_PER_PKT);
    localparam int PW        = ADDR_W + 1;
    localparam int SC_W      = $clog2(SAMPLES_PER_PKT + 1);
    localparam int OFF_W     = $clog2(PKT_BYTES);

    localparam logic [PW-1:0]    DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0]    PKT_LEN  = PW'(PKT_BYTES);
    localparam logic [SC_W-1:0]  SAMP_N   = SC_W'(SAMPLES_PER_PKT);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PKT_BYTES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e           state_q, state_d;
    logic [31:0]      seq_q, seq_d;
    logic [31:0]      smp_q, smp_d;
    logic [SC_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]       bidx_q, bidx_d;
    logic             wr_act_q, wr_act_d;
    logic             drop_q, drop_d;
    logic             pend_q, pend_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             avail_q, avail_d;
    logic [CNT_W-1:0] perr_q, perr_d;
    logic [CNT_W-1:0] dpkt_q, dpkt_d;
    logic [CNT_W-1:0] dsmp_q, dsmp_d;

    logic          par_ok, adc_good, adc_bad;
    logic          start;
    logic [31:0]   start_smp;
    logic [PW-1:0] free;
    logic          we;
    logic [7:0]    wdata;
    logic          pop;

    assign par_ok   = adc_ddr_in[PAR_BIT] == ^adc_ddr_in[31:0];
    assign adc_good = adc_ddr_in[VLD_BIT] && par_ok;
    assign adc_bad  = adc_ddr_in[VLD_BIT] && !par_ok;
    assign cnt_inc  = cnt_q + 1'b1;
    assign free     = DEPTH - (wr_ptr_q - rd_ptr_q);

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        smp_d     = smp_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        wr_act_d  = wr_act_q;
        drop_d    = drop_q;
        pend_d    = pend_q;
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        dpkt_d    = dpkt_q;
        dsmp_d    = dsmp_q;
        perr_d    = adc_bad ? sat_inc(perr_q) : perr_q;
        we        = 1'b0;
        wdata     = '0;
        start     = 1'b0;
        start_smp = adc_ddr_in[31:0];
        unique case (state_q)
            IDLE: start = adc_good;
            HDR: begin
                we       = 1'b1;
                wdata    = be_byte(seq_q, bidx_q);
                wr_ptr_d = wr_ptr_q + 1'b1;
                bidx_d   = bidx_q + 1'b1;
                if (bidx_q == 2'd3) begin
                    state_d  = SAMP;
                    wr_act_d = 1'b1;
                end
                if (adc_good) dsmp_d = sat_inc(dsmp_q);
            end
            SAMP: begin
                if (wr_act_q) begin
                    we       = 1'b1;
                    wdata    = be_byte(smp_q, bidx_q);
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    bidx_d   = bidx_q + 1'b1;
                    // The last byte slot can take the next sample directly.
                    if (bidx_q != 2'd3) begin
                        if (adc_good) dsmp_d = sat_inc(dsmp_q);
                    end else if (cnt_q == SAMP_N) begin
                        state_d  = COMMIT;
                        wr_act_d = 1'b0;
                        if (adc_good) begin
                            pend_d = 1'b1;
                            smp_d  = adc_ddr_in[31:0];
                        end
                    end else if (adc_good) begin
                        smp_d = adc_ddr_in[31:0];
                        cnt_d = cnt_inc;
                    end else begin
                        wr_act_d = 1'b0;
                    end
                end else if (adc_good) begin
                    cnt_d = cnt_inc;
                    if (drop_q) begin
                        if (cnt_inc == SAMP_N) begin
                            state_d = IDLE;
                            drop_d  = 1'b0;
                        end
                    end else begin
                        smp_d    = adc_ddr_in[31:0];
                        wr_act_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                cmt_ptr_d = wr_ptr_q;
                seq_d     = seq_q + 32'd1;
                state_d   = IDLE;
                pend_d    = 1'b0;
                start     = pend_q || adc_good;
                if (pend_q) start_smp = smp_q;
                if (pend_q && adc_good) dsmp_d = sat_inc(dsmp_q);
            end
        endcase
        if (start) begin
            smp_d  = start_smp;
            cnt_d  = SC_W'(1);
            bidx_d = 2'd0;
            if (free >= PKT_LEN) begin
                state_d = HDR;
            end else begin
                seq_d   = seq_d + 32'd1;
                dpkt_d  = sat_inc(dpkt_q);
                drop_d  = SAMPLES_PER_PKT != 1;
                state_d = (SAMPLES_PER_PKT == 1) ? IDLE : SAMP;
            end
        end
    end

    always_comb begin
        pop      = pkt_rd && (rd_ptr_q != cmt_ptr_q);
        rd_ptr_d = rd_ptr_q;
        off_d    = off_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            sop_d    = off_q == '0;
            eop_d    = off_q == OFF_LAST;
            off_d    = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
        end
        avail_d = rd_ptr_d != cmt_ptr_d;
    end

    always_ff @(posedge clk125 or negedge clk125_rst_n) begin
        if (!clk125_rst_n) begin
            state_q   <= IDLE;
            seq_q     <= '0;
            smp_q     <= '0;
            cnt_q     <= '0;
            bidx_q    <= '0;
            wr_act_q  <= 1'b0;
            drop_q    <= 1'b0;
            pend_q    <= 1'b0;
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            off_q     <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            avail_q   <= 1'b0;
            perr_q    <= '0;
            dpkt_q    <= '0;
            dsmp_q    <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            wr_act_q  <= wr_act_d;
            drop_q    <= drop_d;
            pend_q    <= pend_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            off_q     <= off_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            avail_q   <= avail_d;
            perr_q    <= perr_d;
            dpkt_q    <= dpkt_d;
            dsmp_q    <= dsmp_d;
        end
    end

    adc_pkt_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk125),
        .rst_ni  (clk125_rst_n),
        .we_i    (we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .re_i    (pop),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (pkt_byte)
    );

    assign pkt_sop        = sop_q;
    assign pkt_eop        = eop_q;
    assign pkt_avail      = avail_q;
    assign parity_err_cnt = perr_q;
    assign drop_pkt_cnt   = dpkt_q;
    assign drop_smp_cnt   = dsmp_q;

endmodule

// File: tb/tb_adc_udp_packetizer.sv
// Directed bench for adc_udp_packetizer with 4-sample packets
// in a 64-byte buffer (room for three packets).
module tb_adc_udp_packetizer;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int PB = 4 + 4 * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] adc = '0;
    logic        pkt_rd = 1'b0;
    logic [7:0]  pkt_byte;
    logic        pkt_sop, pkt_eop, pkt_avail;
    logic [15:0] perr, dpkt, dsmp;

    int vectors = 0;
    int errs    = 0;

    logic [15:0] si [N];
    logic [15:0] sq [N];
    logic [7:0]  exp_b [PB];

    adc_udp_packetizer #(
        .SAMPLES_PER_PKT (N),
        .ADDR_W          (AW),
        .CNT_W           (16)
    ) dut (
        .clk125         (clk),
        .clk125_rst_n   (rst_n),
        .adc_ddr_in     (adc),
        .pkt_rd         (pkt_rd),
        .pkt_byte       (pkt_byte),
        .pkt_sop        (pkt_sop),
        .pkt_eop        (pkt_eop),
        .pkt_avail      (pkt_avail),
        .parity_err_cnt (perr),
        .drop_pkt_cnt   (dpkt),
        .drop_smp_cnt   (dsmp)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q,
                        input bit bad, input int gap);
        logic p;
        p   = (^{i, q}) ^ bad;
        adc = {1'b1, p, i, q};
        tick();
        adc = '0;
        for (int k = 0; k < gap - 1; k++) tick();
    endtask

    task automatic send_pkt(input int gap);
        for (int k = 0; k < N; k++) send(si[k], sq[k], 1'b0, gap);
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic build_exp(input logic [31:0] seq);
        exp_b[0] = seq[31:24];
        exp_b[1] = seq[23:16];
        exp_b[2] = seq[15:8];
        exp_b[3] = seq[7:0];
        for (int k = 0; k < N; k++) begin
            exp_b[4 + 4*k] = si[k][15:8];
            exp_b[5 + 4*k] = si[k][7:0];
            exp_b[6 + 4*k] = sq[k][15:8];
            exp_b[7 + 4*k] = sq[k][7:0];
        end
    endtask

    task automatic wait_avail(input string tag);
        for (int k = 0; k < 64 && !pkt_avail; k++) tick();
        chk(tag, pkt_avail, 1);
    endtask

    // idle_after > 0 inserts one idle cycle after that many pops.
    task automatic read_pkt(input string tag, input int idle_after);
        for (int k = 0; k < PB; k++) begin
            pkt_rd = 1'b1;
            tick();
            chk($sformatf("%s b%0d", tag, k), pkt_byte, exp_b[k]);
            chk($sformatf("%s sop%0d", tag, k), pkt_sop, k == 0);
            chk($sformatf("%s eop%0d", tag, k), pkt_eop, k == PB - 1);
            if (k == idle_after - 1) begin
                pkt_rd = 1'b0;
                tick();
                chk($sformatf("%s hold", tag), pkt_byte, exp_b[k]);
            end
        end
        pkt_rd = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " byte"}, pkt_byte, 0);
        chk({tag, " sop"}, pkt_sop, 0);
        chk({tag, " eop"}, pkt_eop, 0);
        chk({tag, " avail"}, pkt_avail, 0);
        chk({tag, " perr"}, perr, 0);
        chk({tag, " dpkt"}, dpkt, 0);
        chk({tag, " dsmp"}, dsmp, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic packet, slow samples, continuous read.
        for (int k = 0; k < N; k++) begin
            si[k] = 16'(k);
            sq[k] = 16'(k);
        end
        send_pkt(1250);
        wait_avail("basic avail");
        build_exp(0);
        read_pkt("basic", 0);
        chk("basic avail low", pkt_avail, 0);
        pkt_rd = 1'b1;
        tick();
        tick();
        pkt_rd = 1'b0;
        chk("empty rd byte", pkt_byte, 8'h03);
        chk("empty rd eop", pkt_eop, 1);

        // Bad-parity sample ahead of the packet.
        si = '{16'h1234, 16'h8001, 16'hFFFF, 16'h00A5};
        sq = '{16'hABCD, 16'h7FFE, 16'h0000, 16'h5A00};
        send(16'hDEAD, 16'hBEEF, 1'b1, 12);
        send_pkt(12);
        chk("perr", perr, 1);
        wait_avail("perr avail");
        build_exp(1);
        read_pkt("perr", 0);

        // Stalled MAC read: 6 pops, 1 idle, then the rest.
        si = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        sq = '{16'h1112, 16'h1314, 16'h1516, 16'h1718};
        send_pkt(12);
        wait_avail("stall avail");
        build_exp(2);
        read_pkt("stall", 6);
        chk("stall avail low", pkt_avail, 0);

        // Second sample 2 cycles after the first is lost.
        send(16'hA000, 16'hB000, 1'b0, 2);
        send(16'hEEEE, 16'hEEEE, 1'b0, 12);
        si = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        sq = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
        for (int k = 1; k < N; k++) send(si[k], sq[k], 1'b0, 12);
        for (int k = 0; k < 12; k++) tick();
        chk("b2b dsmp", dsmp, 1);
        wait_avail("b2b avail");
        build_exp(3);
        read_pkt("b2b", 0);

        // Overflow: three packets fit, next two are dropped.
        si = '{16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03};
        sq = '{16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03};
        for (int p = 0; p < 5; p++) send_pkt(12);
        chk("ovf dpkt", dpkt, 2);
        chk("ovf dsmp", dsmp, 1);
        chk("ovf avail", pkt_avail, 1);
        for (int p = 0; p < 3; p++) begin
            build_exp(32'(4 + p));
            read_pkt($sformatf("ovf%0d", p), 0);
        end
        chk("ovf drained", pkt_avail, 0);
        send_pkt(12);
        wait_avail("skip avail");
        build_exp(9);
        read_pkt("skip", 0);

        // Reset in the middle of a packet.
        send(16'h5555, 16'h6666, 1'b0, 12);
        send(16'h7777, 16'h8888, 1'b0, 12);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        si = '{16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03};
        sq = '{16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03};
        send_pkt(12);
        wait_avail("post avail");
        build_exp(0);
        read_pkt("post", 0);
        chk("post avail low", pkt_avail, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/adc_udp_packetizer.md
Name: adc_udp_packetizer

Overview:
- Upstream neighbour of the Ethernet MAC's UDP packet read port in eth_top.
- Takes the 34-bit ADC word stream on P1A_DDR: bit 33 is valid, bit 32 is parity, bits 31:16 are I, bits 15:0 are Q.
- Checks parity, frames a fixed number of good samples behind a 4-byte sequence header, and stores bytes in an internal RAM.
- Exposes only whole committed packets to the MAC through a SOP/EOP byte-read interface.

Parameters:
- SAMPLES_PER_PKT, 256: good samples per packet. Packet length PKT_BYTES = 4 + 4*SAMPLES_PER_PKT (1028 at default).
- ADDR_W, 12: byte RAM address width. Depth 2^ADDR_W must be at least 2*PKT_BYTES.
- CNT_W, 16: width of the error and drop counters.

Ports:
- clk125  in  1  single clock, 125 MHz.
- clk125_rst_n  in  1  asynchronous, active-low reset.
- adc_ddr_in  in  34  [33] valid, [32] parity, [31:16] I, [15:0] Q.
- pkt_rd  in  1  MAC read strobe; one byte popped per cycle while high.
- pkt_byte  out  8  packet byte.
- pkt_sop  out  1  first byte of packet.
- pkt_eop  out  1  last byte of packet.
- pkt_avail  out  1  at least one committed, not-fully-read packet exists.
- parity_err_cnt  out  CNT_W  samples rejected for bad parity; saturates.
- drop_pkt_cnt  out  CNT_W  packets discarded for lack of space; saturates.
- drop_smp_cnt  out  CNT_W  good samples discarded because the serializer was busy; saturates.

Behaviour:
- Reset values: all outputs 0; write, commit and read pointers 0; sequence number 0; state IDLE.
- Reset asserted mid-operation: the partial packet is discarded and sequence restarts at 0.
- Parity:
  - Sample accepted only when adc_ddr_in[33]=1 and adc_ddr_in[32] == ^adc_ddr_in[31:0].
  - On mismatch: sample ignored, parity_err_cnt++.
- Write FSM states: IDLE, HDR, SAMP, COMMIT. Writes 1 byte/cycle.
  - IDLE, good sample arrives: latch sample. Compute free = depth - (wr_ptr - rd_ptr) at ADDR_W+1 bits.
    - If free >= PKT_BYTES: go to HDR.
    - Else: set drop flag for this packet, seq++, drop_pkt_cnt++. Subsequent samples of this packet are counted toward SAMPLES_PER_PKT but not written.
  - HDR: 4 cycles. Write seq[31:24], [23:16], [15:8], [7:0], then go to SAMP.
  - SAMP: 4 cycles. Write I[15:8], I[7:0], Q[15:8], Q[7:0]. Then:
    - if sample count == SAMPLES_PER_PKT: go to COMMIT;
    - else: return to a wait sub-state (still SAMP-armed, no write).
  - A good sample arriving while HDR/SAMP is writing is dropped; drop_smp_cnt++.
  - Spacing guarantee: no loss if good samples are at least 8 cycles apart (header case) or 4 cycles apart otherwise.
  - COMMIT: 1 cycle. commit_ptr <- wr_ptr, seq++, then IDLE. Dropped packets skip the commit but still advance seq.
- Pointers: ADDR_W+1 bits with wrap bit; the RAM address is the low ADDR_W bits.
- Read side:
  - pkt_avail = (rd_ptr != commit_ptr), registered.
  - pkt_rd with rd_ptr != commit_ptr pops one byte. pkt_byte, pkt_sop and pkt_eop update on the following cycle (1-cycle latency) and hold until the next pop.
  - pkt_rd with rd_ptr == commit_ptr is ignored. Reads never cross into an uncommitted packet.
  - Read byte offset counter: pkt_sop when offset==0, pkt_eop when offset==PKT_BYTES-1, then offset wraps to 0.
  - The MAC may deassert pkt_rd anywhere mid-packet; the stream resumes intact.
- Simultaneous COMMIT and pop: both take effect that cycle. pkt_avail reflects the new pointers next cycle.
- Counters saturate at all-ones.

Decomposition:
- Package adc_pkt_pkg holds:
  - state enum {IDLE, HDR, SAMP, COMMIT};
  - HDR_BYTES=4 and BYTES_PER_SMP=4;
  - a function pkt_bytes(samples);
  - the ADC word field index constants (VLD_BIT=33, PAR_BIT=32).
- Sub-module adc_pkt_ram: simple dual-port byte RAM, one write port and one registered read port, 2^ADDR_W deep, inferable to EBR.

Test Plan:
- Basic packet, SAMPLES_PER_PKT=4, good samples I=Q=0..3 spaced 1250 clocks, continuous read:
  - expect 20 bytes: 00 00 00 00, 00 00 00 00, 00 01 00 01, 00 02 00 02, 00 03 00 03;
  - SOP on byte 0, EOP on byte 19; pkt_avail falls after the last pop;
  - second packet header is 00 00 00 01.
- Parity error: one sample with bit 32 inverted -> parity_err_cnt=1; the packet contains only the next 4 good samples.
- Overflow: ADDR_W=6, SAMPLES_PER_PKT=4, pkt_rd held 0:
  - 3 packets commit, 4th and later dropped, drop_pkt_cnt increments;
  - after draining, the next packet header shows the skipped seq value.
- MAC read pattern: 6 pops, 1 idle, then pops until EOP -> byte stream identical to the continuous-read case; no duplicated or lost bytes.
- Reset mid-packet: assert clk125_rst_n low after 2 of 4 samples -> all outputs 0 immediately; next packet seq=0 with no residue.
- Back-to-back good samples 2 cycles apart -> second dropped, drop_smp_cnt=1; packet content excludes it.
